// File: rtl/lcd_text_pkg.sv
`default_nettype none
// ============================================================================
// Module  : lcd_text_pkg
// Brief   : Shared constants and types for the LCD text-layer controller.
// Revision: 1.0 - initial release
// ============================================================================
package lcd_text_pkg;

  localparam int unsigned c_char_w  = 8;
  localparam int unsigned c_char_h  = 16;
  localparam int unsigned c_font_aw = 12;

  localparam logic [15:0] c_rgb_white = 16'hFFFF;
  localparam logic [15:0] c_rgb_blue  = 16'h001F;

  // Owner of the text RAM port for the coming cycle
  typedef enum logic [1:0] {
    GNT_IDLE = 2'd0,
    GNT_DISP = 2'd1,
    GNT_HOST = 2'd2,
    GNT_DROP = 2'd3
  } txt_grant_e;

  function automatic logic [c_font_aw-1:0] font_index(input logic [7:0] code,
                                                      input logic [3:0] line);
    return {code, line};
  endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_text_arb.sv
`default_nettype none
// ============================================================================
// Module  : lcd_text_arb
// Brief   : Single-port text RAM mux: display fetch first, host writes on
//           spare cycles with a 1-cycle ack and out-of-range drop.
// Revision: 1.0 - initial release
// ============================================================================
module lcd_text_arb
  import lcd_text_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned CELLS  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_fetch,
  input  logic [ADDR_W-1:0] i_fetch_addr,
  input  logic              i_host_req,
  input  logic [ADDR_W-1:0] i_host_addr,
  input  logic [7:0]        i_host_wdata,
  output logic              o_host_ack,
  output logic [ADDR_W-1:0] o_txt_addr,
  output logic              o_txt_rd_en,
  output logic              o_txt_wr_en,
  output logic [7:0]        o_txt_wdata
);

  txt_grant_e        w_grant;
  logic              w_host_in_range;
  logic              r_host_ack;
  logic [ADDR_W-1:0] r_txt_addr;
  logic              r_txt_rd_en;
  logic              r_txt_wr_en;
  logic [7:0]        r_txt_wdata;

  assign w_host_in_range = 32'(i_host_addr) < CELLS;

  // The ack of the previous grant blocks this cycle, so a host still holding
  // req while it sees its ack is never granted twice.
  always_comb begin
    w_grant = GNT_IDLE;
    if (i_fetch) begin
      w_grant = GNT_DISP;
    end else if (i_host_req && !r_host_ack) begin
      w_grant = w_host_in_range ? GNT_HOST : GNT_DROP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_host_ack  <= 1'b0;
      r_txt_addr  <= '0;
      r_txt_rd_en <= 1'b0;
      r_txt_wr_en <= 1'b0;
      r_txt_wdata <= '0;
    end else begin
      r_txt_rd_en <= (w_grant == GNT_DISP);
      r_txt_wr_en <= (w_grant == GNT_HOST);
      r_host_ack  <= (w_grant == GNT_HOST) || (w_grant == GNT_DROP);
      case (w_grant)
        GNT_DISP: r_txt_addr <= i_fetch_addr;
        GNT_HOST: begin
          r_txt_addr  <= i_host_addr;
          r_txt_wdata <= i_host_wdata;
        end
        default: ;
      endcase
    end
  end

  assign o_host_ack  = r_host_ack;
  assign o_txt_addr  = r_txt_addr;
  assign o_txt_rd_en = r_txt_rd_en;
  assign o_txt_wr_en = r_txt_wr_en;
  assign o_txt_wdata = r_txt_wdata;

endmodule
`default_nettype wire

// File: rtl/lcd_text_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : lcd_text_ctrl
// Brief   : Text-layer pixel generator: coordinate decode, text RAM / font ROM
//           lookup pipeline and RGB565 output, fixed 3-cycle latency.
// Revision: 1.0 - initial release
// ============================================================================
module lcd_text_ctrl
  import lcd_text_pkg::*;
#(
  parameter int unsigned WIN_X  = 16,
  parameter int unsigned WIN_Y  = 32,
  parameter int unsigned COLS   = 64,
  parameter int unsigned ROWS   = 16,
  parameter int unsigned ADDR_W = 10,
  parameter logic [15:0] FG     = c_rgb_white,
  parameter logic [15:0] BG     = c_rgb_blue
) (
  input  logic                 lcd_clk,
  input  logic                 sys_rst,
  input  logic [9:0]           pixel_xpos,
  input  logic [9:0]           pixel_ypos,
  output logic [15:0]          pixel_data,
  output logic [ADDR_W-1:0]    txt_addr,
  output logic                 txt_rd_en,
  output logic                 txt_wr_en,
  output logic [7:0]           txt_wdata,
  input  logic [7:0]           txt_rdata,
  output logic [c_font_aw-1:0] font_addr,
  input  logic [7:0]           font_rdata,
  input  logic                 host_req,
  input  logic [ADDR_W-1:0]    host_addr,
  input  logic [7:0]           host_wdata,
  output logic                 host_ack
);

  localparam int unsigned c_win_x_end = WIN_X + c_char_w * COLS;
  localparam int unsigned c_win_y_end = WIN_Y + c_char_h * ROWS;
  localparam int unsigned c_cells     = COLS * ROWS;

  // Stage 0: coordinate decode
  logic [9:0]        w_rx;
  logic [9:0]        w_ry;
  logic              w_in_win;
  logic [6:0]        w_col;
  logic [5:0]        w_row;
  logic [3:0]        w_line;
  logic [2:0]        w_bit;
  logic              w_fetch;
  logic [ADDR_W-1:0] w_fetch_addr;

  assign w_rx   = pixel_xpos - 10'(WIN_X);
  assign w_ry   = pixel_ypos - 10'(WIN_Y);
  assign w_col  = w_rx[9:3];
  assign w_bit  = w_rx[2:0];
  assign w_row  = w_ry[9:4];
  assign w_line = w_ry[3:0];

  assign w_in_win = (32'(pixel_xpos) >= WIN_X) && (32'(pixel_xpos) < c_win_x_end) &&
                    (32'(pixel_ypos) >= WIN_Y) && (32'(pixel_ypos) < c_win_y_end);

  // One text RAM read per character cell, on its leftmost pixel
  assign w_fetch      = w_in_win && (w_bit == 3'd0);
  assign w_fetch_addr = ADDR_W'(32'(w_row) * COLS + 32'(w_col));

  lcd_text_arb #(
    .ADDR_W (ADDR_W),
    .CELLS  (c_cells)
  ) u_arb (
    .clk          (lcd_clk),
    .rst          (sys_rst),
    .i_fetch      (w_fetch),
    .i_fetch_addr (w_fetch_addr),
    .i_host_req   (host_req),
    .i_host_addr  (host_addr),
    .i_host_wdata (host_wdata),
    .o_host_ack   (host_ack),
    .o_txt_addr   (txt_addr),
    .o_txt_rd_en  (txt_rd_en),
    .o_txt_wr_en  (txt_wr_en),
    .o_txt_wdata  (txt_wdata)
  );

  // Stage 1: character code -> font address
  logic                 r_s1_valid;
  logic [3:0]           r_s1_line;
  logic [2:0]           r_s1_bit;
  logic [7:0]           r_code;
  logic [7:0]           w_code;
  logic [c_font_aw-1:0] r_font_addr;

  // txt_rd_en high means the previous cycle was a fetch slot and rdata is fresh
  assign w_code = txt_rd_en ? txt_rdata : r_code;

  always_ff @(posedge lcd_clk) begin
    if (sys_rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_line   <= '0;
      r_s1_bit    <= '0;
      r_code      <= '0;
      r_font_addr <= '0;
    end else begin
      r_s1_valid  <= w_in_win;
      r_s1_line   <= w_line;
      r_s1_bit    <= w_bit;
      r_code      <= w_code;
      r_font_addr <= (r_s1_valid) ? font_index(w_code, r_s1_line) : r_font_addr;
    end
  end

  // Stage 2: font row bit select; stage 3: colour register
  logic        r_s2_valid;
  logic [2:0]  r_s2_bit;
  logic        w_sel;
  logic [15:0] r_pixel_data;

  assign w_sel = font_rdata[3'd7 - r_s2_bit];

  always_ff @(posedge lcd_clk) begin
    if (sys_rst) begin
      r_s2_valid   <= 1'b0;
      r_s2_bit     <= '0;
      r_pixel_data <= BG;
    end else begin
      r_s2_valid   <= r_s1_valid;
      r_s2_bit     <= r_s1_bit;
      r_pixel_data <= (r_s2_valid && w_sel) ? FG : BG;
    end
  end

  assign font_addr  = r_font_addr;
  assign pixel_data = r_pixel_data;

endmodule
`default_nettype wire

// File: tb/tb_lcd_text_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_lcd_text_ctrl
// Brief   : Directed bench for lcd_text_ctrl with text RAM / font ROM models.
// Revision: 1.0 - initial release
// ============================================================================
module tb_lcd_text_ctrl;

  localparam int WIN_X  = 16;
  localparam int WIN_Y  = 32;
  localparam int COLS   = 64;
  localparam int ROWS   = 16;
  // One spare address bit so that host_addr = COLS*ROWS is representable
  localparam int ADDR_W = 11;
  localparam logic [15:0] FG = 16'hFFFF;
  localparam logic [15:0] BG = 16'h001F;

  logic              lcd_clk;
  logic              sys_rst;
  logic [9:0]        pixel_xpos, pixel_ypos;
  logic [15:0]       pixel_data;
  logic [ADDR_W-1:0] txt_addr;
  logic              txt_rd_en, txt_wr_en;
  logic [7:0]        txt_wdata, txt_rdata;
  logic [11:0]       font_addr;
  logic [7:0]        font_rdata;
  logic              host_req;
  logic [ADDR_W-1:0] host_addr;
  logic [7:0]        host_wdata;
  logic              host_ack;

  lcd_text_ctrl #(
    .WIN_X(WIN_X), .WIN_Y(WIN_Y), .COLS(COLS), .ROWS(ROWS),
    .ADDR_W(ADDR_W), .FG(FG), .BG(BG)
  ) dut (
    .lcd_clk(lcd_clk), .sys_rst(sys_rst),
    .pixel_xpos(pixel_xpos), .pixel_ypos(pixel_ypos), .pixel_data(pixel_data),
    .txt_addr(txt_addr), .txt_rd_en(txt_rd_en), .txt_wr_en(txt_wr_en),
    .txt_wdata(txt_wdata), .txt_rdata(txt_rdata),
    .font_addr(font_addr), .font_rdata(font_rdata),
    .host_req(host_req), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack)
  );

  initial lcd_clk = 1'b0;
  always #5 lcd_clk = ~lcd_clk;

  logic [7:0] txt_mem  [0:2047];
  logic [7:0] font_rom [0:4095];
  logic [7:0] exp_txt  [0:2047];

  assign txt_rdata  = txt_mem[txt_addr];
  assign font_rdata = font_rom[font_addr];
  always @(posedge lcd_clk) if (txt_wr_en) txt_mem[txt_addr] <= txt_wdata;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] model_pix(input int x, input int y);
    int rx, ry;
    logic [7:0] code, frow;
    if (x < WIN_X || x >= WIN_X + 8*COLS || y < WIN_Y || y >= WIN_Y + 16*ROWS) return BG;
    rx   = x - WIN_X;
    ry   = y - WIN_Y;
    code = exp_txt[(ry/16)*COLS + rx/8];
    frow = font_rom[int'(code)*16 + ry%16];
    return frow[7 - (rx%8)] ? FG : BG;
  endfunction

  // Expected pixels of the last three presented coordinates
  logic [15:0] h0, h1, h2;
  logic        h0v = 1'b0, h1v = 1'b0, h2v = 1'b0;
  logic        chk_pix = 1'b0;

  task automatic cyc(input int x, input int y);
    pixel_xpos = 10'(x);
    pixel_ypos = 10'(y);
    if (sys_rst) begin
      h0v = 1'b0; h1v = 1'b0; h2v = 1'b0;
    end else begin
      h2 = h1; h2v = h1v; h1 = h0; h1v = h0v;
      h0 = model_pix(x, y); h0v = 1'b1;
    end
    @(posedge lcd_clk);
    #1;
    if (chk_pix && h2v) check($sformatf("pixel(x=%0d,y=%0d)", x, y), 32'(pixel_data), 32'(h2));
  endtask

  typedef struct {
    int          x;
    int          y;
    logic [15:0] pix;
    logic        rd;
  } vec_t;
  vec_t tbl[$];

  int   wr_cnt;
  logic prev_ack, cur_fetch;

  initial begin
    for (int i = 0; i < 2048; i++) begin
      txt_mem[i] <= 8'h00;
      exp_txt[i] = 8'h00;
    end
    for (int i = 0; i < 4096; i++) font_rom[i] = 8'h00;
    txt_mem[0]    <= 8'h41; exp_txt[0]    = 8'h41;
    txt_mem[2]    <= 8'h41; exp_txt[2]    = 8'h41;
    txt_mem[960]  <= 8'h41; exp_txt[960]  = 8'h41;
    txt_mem[1024] <= 8'h5A; exp_txt[1024] = 8'h5A;
    font_rom[16'h41*16 + 5]  = 8'b1000_0001;
    font_rom[16'h41*16 + 15] = 8'b1000_0000;
    font_rom[16'h42*16 + 5]  = 8'b0011_1100;

    // Table: sweep of row y=37 across cells 0..2, then window edges
    tbl.push_back('{14, 37, BG, 1'b0});
    tbl.push_back('{15, 37, BG, 1'b0});
    tbl.push_back('{16, 37, FG, 1'b1});
    for (int x = 17; x <= 22; x++) tbl.push_back('{x, 37, BG, 1'b0});
    tbl.push_back('{23, 37, FG, 1'b0});
    tbl.push_back('{24, 37, BG, 1'b1});
    for (int x = 25; x <= 31; x++) tbl.push_back('{x, 37, BG, 1'b0});
    tbl.push_back('{32, 37, FG, 1'b1});
    tbl.push_back('{33, 37, BG, 1'b0});
    tbl.push_back('{0,   0,  BG, 1'b0});
    tbl.push_back('{528, 37, BG, 1'b0});
    tbl.push_back('{16,  31, BG, 1'b0});
    tbl.push_back('{16,  287, FG, 1'b1});
    tbl.push_back('{16,  288, BG, 1'b0});
    tbl.push_back('{0,   0,  BG, 1'b0});
    tbl.push_back('{0,   0,  BG, 1'b0});

    // Reset held with a pending host request and an in-window fetch slot
    sys_rst = 1'b1; host_req = 1'b1; host_addr = 11'd3; host_wdata = 8'h33;
    for (int k = 0; k < 3; k++) begin
      cyc(24, 40);
      check("rst_pixel", 32'(pixel_data), 32'(BG));
      check("rst_ack", 32'(host_ack), 0);
      check("rst_rd_en", 32'(txt_rd_en), 0);
      check("rst_wr_en", 32'(txt_wr_en), 0);
    end
    sys_rst = 1'b0; host_req = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].x, tbl[i].y);
      check($sformatf("tbl%0d_rd_en", i), 32'(txt_rd_en), 32'(tbl[i].rd));
      if (i >= 2) check($sformatf("tbl%0d_pixel", i - 2), 32'(pixel_data), 32'(tbl[i-2].pix));
    end

    // Reset mid-line: x=16 (FG) is in flight and must be dropped
    cyc(14, 37); cyc(15, 37); cyc(16, 37); cyc(17, 37);
    sys_rst = 1'b1;
    cyc(18, 37);
    sys_rst = 1'b0;
    check("rel_r0", 32'(pixel_data), 32'(BG));
    cyc(16, 37); check("rel_r1", 32'(pixel_data), 32'(BG));
    cyc(17, 37); check("rel_r2", 32'(pixel_data), 32'(BG));
    cyc(18, 37); check("rel_r3", 32'(pixel_data), 32'(FG));
    for (int x = 19; x <= 23; x++) cyc(x, 37);
    cyc(0, 0); cyc(0, 0);

    // Host write requested in the cycle before a fetch slot
    chk_pix = 1'b1;
    host_addr = 11'd5; host_wdata = 8'h42;
    for (int x = 16; x <= 34; x++) begin
      host_req = (x == 31);
      cyc(x, 37);
      if (x == 31) begin
        check("pre_fetch_ack", 32'(host_ack), 1);
        check("pre_fetch_wr_en", 32'(txt_wr_en), 1);
        check("pre_fetch_rd_en", 32'(txt_rd_en), 0);
        check("pre_fetch_addr", 32'(txt_addr), 5);
        check("pre_fetch_wdata", 32'(txt_wdata), 32'h42);
        exp_txt[5] = 8'h42;
      end
      if (x == 32) begin
        check("fetch_ack", 32'(host_ack), 0);
        check("fetch_wr_en", 32'(txt_wr_en), 0);
        check("fetch_rd_en", 32'(txt_rd_en), 1);
      end
    end
    host_req = 1'b0;
    cyc(0, 0);
    check("ram5", 32'(txt_mem[5]), 32'h42);
    cyc(0, 0);
    for (int x = 56; x <= 66; x++) cyc(x, 37);
    cyc(0, 0); cyc(0, 0); cyc(0, 0);

    // 20 back-to-back host writes during active video
    wr_cnt = 0; prev_ack = 1'b0;
    host_req = 1'b1; host_addr = 11'd100; host_wdata = 8'h60;
    for (int k = 0; k < 200 && wr_cnt < 20; k++) begin
      cur_fetch = ((k % 8) == 0);
      cyc(16 + k, 37);
      check("rd_wr_overlap", 32'(txt_rd_en & txt_wr_en), 0);
      if (host_ack) begin
        check("ack_adjacent", 32'(prev_ack), 0);
        check("ack_on_fetch", 32'(cur_fetch), 0);
        exp_txt[host_addr] = host_wdata;
        wr_cnt++;
        host_addr  = host_addr + 11'd1;
        host_wdata = host_wdata + 8'd1;
        if (wr_cnt == 20) host_req = 1'b0;
      end
      prev_ack = host_ack;
    end
    check("writes_done", 32'(wr_cnt), 20);
    cyc(0, 0);
    for (int i = 0; i < 20; i++)
      check($sformatf("ram%0d", 100 + i), 32'(txt_mem[100 + i]), 32'(8'h60 + i));
    cyc(0, 0); cyc(0, 0);

    // Out-of-range host address: acked, dropped
    host_req = 1'b1; host_addr = 11'd1024; host_wdata = 8'hEE;
    cyc(0, 0);
    check("oor_ack", 32'(host_ack), 1);
    check("oor_wr_en", 32'(txt_wr_en), 0);
    host_req = 1'b0;
    cyc(0, 0);
    check("oor_ack_clr", 32'(host_ack), 0);
    check("oor_ram1024", 32'(txt_mem[1024]), 32'h5A);
    check("oor_ram0", 32'(txt_mem[0]), 32'h41);

    // Outside the window every non-blocked cycle is a host slot
    host_req = 1'b1; host_addr = 11'd300; host_wdata = 8'h90;
    for (int k = 0; k < 10; k++) begin
      if (k % 2 == 0) cyc(528, 37); else cyc(0, 0);
      check($sformatf("ow%0d_ack", k), 32'(host_ack), 32'((k % 2) == 0));
      check($sformatf("ow%0d_wr_en", k), 32'(txt_wr_en), 32'((k % 2) == 0));
      check($sformatf("ow%0d_rd_en", k), 32'(txt_rd_en), 0);
      if (host_ack) begin
        exp_txt[host_addr] = host_wdata;
        host_addr  = host_addr + 11'd1;
        host_wdata = host_wdata + 8'd1;
      end
    end
    host_req = 1'b0;
    cyc(0, 0);
    for (int i = 0; i < 5; i++)
      check($sformatf("ram%0d", 300 + i), 32'(txt_mem[300 + i]), 32'(8'h90 + i));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
